// File: rtl/crc_check_sequencer.sv
// Frame sequencer for the external combinational check_CRC block: collects a
// data/CRC byte pair, waits a settle window, evaluates, and escalates failures.
module crc_check_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_FAILS     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chk_dado,
  output logic [7:0] chk_crc,
  input  logic       ck_crc,
  input  logic       ck_alarme,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       alarm,
  output logic       retry_req,
  output logic [3:0] fail_count,
  output logic       sensor_fault,
  input  logic       clear_fault
);

  typedef enum logic [2:0] {IDLE, GET_CRC, SETTLE, EVAL, FAULT} state_t;

  // Counter is loaded with SETTLE_CYCLES-1 so EVAL samples SETTLE_CYCLES+1 edges after the CRC byte.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] FAIL_LIMIT  = 4'(MAX_FAILS);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [7:0] chk_dado_nxt, chk_crc_nxt, out_data_nxt;
  logic       out_valid_nxt, alarm_nxt, retry_nxt, fault_nxt, ready_nxt;
  logic [3:0] count_nxt, count_inc;
  logic       xfer;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign xfer      = in_valid && in_ready;
  assign count_inc = sat_inc(fail_count);

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    chk_dado_nxt   = chk_dado;
    chk_crc_nxt    = chk_crc;
    out_data_nxt   = out_data;
    out_valid_nxt  = 1'b0;
    alarm_nxt      = 1'b0;
    retry_nxt      = 1'b0;
    count_nxt      = fail_count;
    fault_nxt      = sensor_fault;

    if (clear_fault) begin
      count_nxt = 4'd0;
      fault_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (xfer) begin
          chk_dado_nxt = in_byte;
          state_nxt    = GET_CRC;
        end
      end
      GET_CRC: begin
        if (xfer) begin
          chk_crc_nxt    = in_byte;
          settle_cnt_nxt = SETTLE_LOAD;
          state_nxt      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) state_nxt = EVAL;
        else                    settle_cnt_nxt = settle_cnt - 4'd1;
      end
      EVAL: begin
        state_nxt = IDLE;
        if (ck_crc) begin
          out_data_nxt  = chk_dado;
          out_valid_nxt = 1'b1;
          alarm_nxt     = ck_alarme;
          count_nxt     = 4'd0;
        end else begin
          retry_nxt = 1'b1;
          // A coincident clear_fault overrides the failure accounting.
          if (!clear_fault) begin
            count_nxt = count_inc;
            if (count_inc >= FAIL_LIMIT) begin
              fault_nxt = 1'b1;
              state_nxt = FAULT;
            end
          end
        end
      end
      FAULT: begin
        if (clear_fault) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == IDLE) || (state_nxt == GET_CRC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      in_ready     <= 1'b0;
      chk_dado     <= 8'h00;
      chk_crc      <= 8'h00;
      out_data     <= 8'h00;
      out_valid    <= 1'b0;
      alarm        <= 1'b0;
      retry_req    <= 1'b0;
      fail_count   <= 4'd0;
      sensor_fault <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_cnt_nxt;
      in_ready     <= ready_nxt;
      chk_dado     <= chk_dado_nxt;
      chk_crc      <= chk_crc_nxt;
      out_data     <= out_data_nxt;
      out_valid    <= out_valid_nxt;
      alarm        <= alarm_nxt;
      retry_req    <= retry_nxt;
      fail_count   <= count_nxt;
      sensor_fault <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_crc_check_sequencer.sv
// Directed, table-driven bench for crc_check_sequencer (SETTLE_CYCLES=2, MAX_FAILS=3).
module tb_crc_check_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] chk_dado, chk_crc, out_data;
  logic       ck_crc, ck_alarme;
  logic       out_valid, alarm, retry_req, sensor_fault, clear_fault;
  logic [3:0] fail_count;

  int n_checks = 0;
  int n_fail   = 0;

  crc_check_sequencer #(.SETTLE_CYCLES(2), .MAX_FAILS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .chk_dado(chk_dado), .chk_crc(chk_crc),
    .ck_crc(ck_crc), .ck_alarme(ck_alarme), .out_data(out_data),
    .out_valid(out_valid), .alarm(alarm), .retry_req(retry_req),
    .fail_count(fail_count), .sensor_fault(sensor_fault),
    .clear_fault(clear_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] crc;
    logic       ck;
    logic       al;
    int         n_ov;
    logic [7:0] odata;
    int         n_alarm;
    int         n_retry;
    logic [3:0] fc;
    logic       sf;
    logic       rdy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready stayed 0 for byte 0x%0h", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int         ov, al, rt;
    logic [7:0] cap;
    logic       stable;
    ov = 0; al = 0; rt = 0; cap = 8'h00; stable = 1'b1;
    ck_crc    = v.ck;
    ck_alarme = v.al;
    send_byte(v.data);
    send_byte(v.crc);
    repeat (6) begin
      @(negedge clk);
      if (out_valid) begin ov++; cap = out_data; end
      if (alarm) al++;
      if (retry_req) rt++;
      if (chk_dado !== v.data || chk_crc !== v.crc) stable = 1'b0;
    end
    check($sformatf("v%0d_out_valid_pulses", idx), ov, v.n_ov);
    if (v.n_ov != 0) check($sformatf("v%0d_out_data", idx), cap, v.odata);
    check($sformatf("v%0d_alarm_pulses", idx), al, v.n_alarm);
    check($sformatf("v%0d_retry_pulses", idx), rt, v.n_retry);
    check($sformatf("v%0d_fail_count", idx), fail_count, v.fc);
    check($sformatf("v%0d_sensor_fault", idx), sensor_fault, v.sf);
    check($sformatf("v%0d_in_ready", idx), in_ready, v.rdy);
    check($sformatf("v%0d_chk_stable", idx), stable, 1'b1);
  endtask

  initial begin
    //            data   crc    ck    al    ov odata  al rt fc     sf    rdy
    vecs[0]  = '{8'h01, 8'h36, 1'b1, 1'b0, 1, 8'h01, 0, 0, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{8'h00, 8'h37, 1'b1, 1'b1, 1, 8'h00, 1, 0, 4'd0, 1'b0, 1'b1};
    vecs[2]  = '{8'h12, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1, 4'd1, 1'b0, 1'b1};
    vecs[3]  = '{8'h34, 8'h00, 1'b0, 1'b1, 0, 8'h00, 0, 1, 4'd2, 1'b0, 1'b1};
    vecs[4]  = '{8'h56, 8'h78, 1'b1, 1'b0, 1, 8'h56, 0, 0, 4'd0, 1'b0, 1'b1};
    vecs[5]  = '{8'hA1, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1, 4'd1, 1'b0, 1'b1};
    vecs[6]  = '{8'hA2, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1, 4'd2, 1'b0, 1'b1};
    vecs[7]  = '{8'hA3, 8'h00, 1'b0, 1'b0, 0, 8'h00, 0, 1, 4'd3, 1'b1, 1'b0};
    vecs[8]  = '{8'h5A, 8'hC3, 1'b1, 1'b0, 1, 8'h5A, 0, 0, 4'd0, 1'b0, 1'b1};
    vecs[9]  = '{8'h99, 8'h11, 1'b0, 1'b0, 0, 8'h00, 0, 1, 4'd1, 1'b0, 1'b1};
    vecs[10] = '{8'h66, 8'h77, 1'b1, 1'b0, 1, 8'h66, 0, 0, 4'd0, 1'b0, 1'b1};

    rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    ck_crc = 1'b0; ck_alarme = 1'b0; clear_fault = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_chk_dado", chk_dado, 8'h00);
    check("rst_chk_crc", chk_crc, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_pulses", {out_valid, alarm, retry_req}, 3'b000);
    check("rst_fail_count", fail_count, 4'd0);
    check("rst_sensor_fault", sensor_fault, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Stuck in FAULT: offered bytes are refused until clear_fault.
    in_byte = 8'hEE; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("fault_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("fault_chk_dado_held", chk_dado, 8'hA3);
    check("fault_sticky", sensor_fault, 1'b1);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    check("clear_sensor_fault", sensor_fault, 1'b0);
    check("clear_fail_count", fail_count, 4'd0);
    check("clear_in_ready", in_ready, 1'b1);

    run_frame(vecs[8], 8);
    run_frame(vecs[9], 9);

    // clear_fault lands exactly on a failing EVAL cycle.
    ck_crc = 1'b0; ck_alarme = 1'b0;
    send_byte(8'h44);
    send_byte(8'h45);
    @(negedge clk);
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    check("coinc_retry_req", retry_req, 1'b1);
    check("coinc_fail_count", fail_count, 4'd0);
    check("coinc_sensor_fault", sensor_fault, 1'b0);
    check("coinc_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check("coinc_retry_width", retry_req, 1'b0);

    run_frame(vecs[9], 9);

    // Reset with only the data byte of a frame delivered.
    send_byte(8'h55);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_chk_dado", chk_dado, 8'h00);
    check("midrst_fail_count", fail_count, 4'd0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_data", out_data, 8'h00);
    rst_n = 1'b1;
    run_frame(vecs[10], 10);

    // Bytes held valid through SETTLE/EVAL are not consumed until IDLE.
    ck_crc = 1'b1; ck_alarme = 1'b0;
    send_byte(8'h21);
    send_byte(8'h22);
    in_byte = 8'hAA; in_valid = 1'b1;
    @(negedge clk);
    check("bp_settle_ready", in_ready, 1'b0);
    @(negedge clk);
    check("bp_eval_ready", in_ready, 1'b0);
    check("bp_chk_dado_held", chk_dado, 8'h21);
    @(negedge clk);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_data", out_data, 8'h21);
    check("bp_resume_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_new_chk_dado", chk_dado, 8'hAA);
    send_byte(8'hBB);
    repeat (4) @(negedge clk);
    check("bp_second_out_data", out_data, 8'hAA);
    check("bp_second_chk_crc", chk_crc, 8'hBB);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
